// File: rtl/arb_pkg.sv
// Shared definitions for the burst grant multiplexer.
//   arb_state_t     : IDLE (arbitrating) / LOCKED (burst in flight)
//   onehot_to_idx() : index of the set bit of a one-hot vector (up to 32 bits)
package arb_pkg;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

   // OR-ing the indices of all set bits gives the index of the single set bit
   // of a one-hot vector. This is cheaper than a priority encoder. An all-zero
   // input yields 0.
   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++)
         if (oh[i]) idx = idx | unsigned'(i);
      return idx;
   endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Combinational fixed-priority arbiter: the lowest set request index wins.
//   req   in  WIDTH  request vector
//   grant out WIDTH  one-hot grant, zero when no request
module fixed_priority_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] grant
);

   // x & -x isolates the lowest set bit
   assign grant = req & (~req + WIDTH'(1));

endmodule

// File: rtl/burst_grant_mux.sv
// Burst-locked grant multiplexer. Arbitrates among WIDTH requesters in IDLE.
// It then locks the winner for a whole burst and steers that requester's
// valid/data/last stream onto one shared valid/ready output port.
//   clk, rst           clock / async active-high reset
//   s_valid[WIDTH]     per-requester valid (also the arbiter request vector)
//   s_data[WIDTH*DW]   packed per-requester data
//   s_last[WIDTH]      per-requester end-of-burst
//   s_ready[WIDTH]     per-requester ready, one-hot or zero
//   m_valid/m_data/m_last/m_ready  shared output handshake
//   m_src              index of the locked requester
//   grant              registered one-hot lock, zero when idle
//   err_long           one-cycle pulse after a forced release at MAX_BEATS
module burst_grant_mux
   import arb_pkg::*;
#(
   parameter int  WIDTH     = 4,
   parameter int  DW        = 32,
   parameter int  MAX_BEATS = 16,
   localparam int SW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    s_valid,
   input  logic [WIDTH*DW-1:0] s_data,
   input  logic [WIDTH-1:0]    s_last,
   output logic [WIDTH-1:0]    s_ready,
   output logic                m_valid,
   output logic [DW-1:0]       m_data,
   output logic                m_last,
   output logic [SW-1:0]       m_src,
   input  logic                m_ready,
   output logic [WIDTH-1:0]    grant,
   output logic                err_long
);

   localparam int CW = $clog2(MAX_BEATS + 1);

   arb_state_t       state;
   logic [CW-1:0]    beat_cnt;
   logic [WIDTH-1:0] arb_grant;
   logic [SW-1:0]    arb_idx;
   logic             locked;
   logic             beat;
   logic [DW-1:0]    s_data_arr [WIDTH];

   fixed_priority_arbiter #(.WIDTH(WIDTH)) u_arb (
      .req   (s_valid),
      .grant (arb_grant)
   );

   assign arb_idx = SW'(onehot_to_idx(32'(arb_grant)));

   for (genvar i = 0; i < WIDTH; i++) begin : g_unpack
      assign s_data_arr[i] = s_data[i*DW +: DW];
   end

   // The output mux is purely combinational. Gating with the lock keeps every
   // output at zero while idle, even though m_src still points at the last owner.
   always_comb begin
      locked  = (state == LOCKED);
      m_valid = locked & s_valid[m_src];
      m_last  = locked & s_last[m_src];
      m_data  = locked ? s_data_arr[m_src] : '0;
      s_ready = grant & {WIDTH{m_ready}};
   end

   assign beat = m_valid & m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         m_src    <= '0;
         beat_cnt <= '0;
         err_long <= 1'b0;
      end else begin
         err_long <= 1'b0;
         case (state)
            IDLE: begin
               if (|s_valid) begin
                  grant    <= arb_grant;
                  m_src    <= arb_idx;
                  beat_cnt <= '0;
                  state    <= LOCKED;
               end
            end
            LOCKED: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + CW'(1);
                  // A real last takes precedence over the length limit.
                  if (m_last) begin
                     state <= IDLE;
                     grant <= '0;
                  end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
                     state    <= IDLE;
                     grant    <= '0;
                     err_long <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
